// File: rtl/aes_sram_responder.sv
// Word-addressed 128-bit state store with registered reads and
// multi-cycle block clear (init) and block dump sequences.
module aes_sram_responder #(
  parameter int NUM_WORDS = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         sramRead,
  input  logic         sramWrite,
  input  logic         sramInit,
  input  logic         sramDump,
  input  logic [15:0]  sramAddr,
  input  logic [2:0]   sramInitNum,
  input  logic [2:0]   sramDumpNum,
  input  logic [127:0] sramWriteValue,
  output logic [127:0] sramReadValue,
  output logic         sram_busy,
  output logic         dump_valid,
  output logic [127:0] dump_data,
  output logic         addr_error
);

  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [12:0] NW = 13'(NUM_WORDS);
  localparam logic [AW-1:0] LAST = AW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, INIT, DUMP} state_t;

  state_t state, state_nx;

  logic [127:0]  mem [NUM_WORDS];
  logic [AW-1:0] ptr;
  logic [2:0]    cnt;
  logic [127:0]  rd_stage;
  logic          rd_pend;

  logic [11:0]   widx;
  logic [AW-1:0] sidx;
  logic          legal;
  logic          sel_init, sel_dump, sel_wr, sel_rd;
  logic          do_wr, do_rd, start, bad;

  assign widx  = sramAddr[15:4];
  assign sidx  = widx[AW-1:0];
  assign legal = (sramAddr[3:0] == 4'd0) && ({1'b0, widx} < NW);

  // Strobe priority: init > dump > write > read
  assign sel_init = sramInit;
  assign sel_dump = !sramInit && sramDump;
  assign sel_wr   = !sramInit && !sramDump && sramWrite;
  assign sel_rd   = !sramInit && !sramDump && !sramWrite && sramRead;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    start    = 1'b0;
    bad      = 1'b0;
    unique case (state)
      IDLE: begin
        if ((sel_init || sel_dump || sel_wr || sel_rd) && !legal)
          bad = 1'b1;
        unique case (1'b1)
          sel_init: if (legal) begin
            state_nx = INIT;
            start    = 1'b1;
          end
          sel_dump: if (legal) begin
            state_nx = DUMP;
            start    = 1'b1;
          end
          sel_wr:  do_wr = legal;
          sel_rd:  do_rd = 1'b1;
          default: ;
        endcase
      end
      INIT, DUMP: if (cnt == 3'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      ptr           <= '0;
      cnt           <= '0;
      rd_stage      <= '0;
      rd_pend       <= 1'b0;
      sramReadValue <= '0;
      addr_error    <= 1'b0;
    end else begin
      addr_error <= bad;
      if (do_wr) mem[sidx] <= sramWriteValue;
      if (state == INIT) mem[ptr] <= '0;
      if (start) begin
        ptr <= sidx;
        cnt <= sel_init ? sramInitNum : sramDumpNum;
      end else if (state != IDLE) begin
        ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        cnt <= cnt - 3'd1;
      end
      // Illegal reads still complete, returning zero
      rd_pend <= do_rd;
      if (do_rd) rd_stage <= legal ? mem[sidx] : '0;
      if (rd_pend) sramReadValue <= rd_stage;
    end
  end

  assign sram_busy  = (state != IDLE);
  assign dump_valid = (state == DUMP);
  assign dump_data  = dump_valid ? mem[ptr] : '0;

endmodule

// File: tb/tb_aes_sram_responder.sv
// Bench for aes_sram_responder: directed table, corner sequences,
// and random traffic against a behavioural model.
module tb_aes_sram_responder;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         sramRead, sramWrite, sramInit, sramDump;
  logic [15:0]  sramAddr;
  logic [2:0]   sramInitNum, sramDumpNum;
  logic [127:0] sramWriteValue;
  logic [127:0] sramReadValue;
  logic         sram_busy, dump_valid, addr_error;
  logic [127:0] dump_data;

  aes_sram_responder #(.NUM_WORDS(16)) dut (
    .clk(clk), .n_rst(n_rst),
    .sramRead(sramRead), .sramWrite(sramWrite),
    .sramInit(sramInit), .sramDump(sramDump),
    .sramAddr(sramAddr),
    .sramInitNum(sramInitNum), .sramDumpNum(sramDumpNum),
    .sramWriteValue(sramWriteValue),
    .sramReadValue(sramReadValue),
    .sram_busy(sram_busy), .dump_valid(dump_valid),
    .dump_data(dump_data), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: array store, remaining beats, 2-edge read delay
  logic [127:0] m_mem [16];
  int           m_left;
  bit           m_init;
  int           m_ptr;
  logic [127:0] m_rv;
  bit           p_v;
  logic [127:0] p_d;
  bit           m_err;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_left = 0;
    m_init = 0;
    m_ptr  = 0;
    m_rv   = '0;
    p_v    = 0;
    p_d    = '0;
    m_err  = 0;
  endtask

  task automatic model_step();
    int  idx;
    bit  ok;
    m_err = 0;
    if (p_v) m_rv = p_d;
    p_v = 0;
    idx = int'(sramAddr) / 16;
    ok  = (sramAddr % 16 == 0) && (idx < 16);
    if (m_left > 0) begin
      if (m_init) m_mem[m_ptr] = '0;
      m_ptr  = (m_ptr + 1) % 16;
      m_left = m_left - 1;
    end else if (sramInit) begin
      m_err = !ok;
      if (ok) begin
        m_init = 1; m_ptr = idx; m_left = int'(sramInitNum) + 1;
      end
    end else if (sramDump) begin
      m_err = !ok;
      if (ok) begin
        m_init = 0; m_ptr = idx; m_left = int'(sramDumpNum) + 1;
      end
    end else if (sramWrite) begin
      m_err = !ok;
      if (ok) m_mem[idx] = sramWriteValue;
    end else if (sramRead) begin
      m_err = !ok;
      p_v = 1;
      p_d = ok ? m_mem[idx] : '0;
    end
  endtask

  task automatic step();
    logic       e_dv;
    @(posedge clk);
    model_step();
    #1;
    e_dv = (m_left > 0) && !m_init;
    chk("rv",   sramReadValue, m_rv);
    chk("busy", 128'(sram_busy), 128'(m_left > 0));
    chk("dv",   128'(dump_valid), 128'(e_dv));
    chk("dd",   dump_data, e_dv ? m_mem[m_ptr] : 128'h0);
    chk("err",  128'(addr_error), 128'(m_err));
  endtask

  task automatic drive(bit rd, bit wr, bit in, bit dp,
                       logic [15:0] a, logic [127:0] wv);
    sramRead       = rd;
    sramWrite      = wr;
    sramInit       = in;
    sramDump       = dp;
    sramAddr       = a;
    sramWriteValue = wv;
  endtask

  typedef struct {
    bit           rd, wr, in, dp;
    logic [15:0]  addr;
    logic [127:0] wv;
    logic [127:0] exp_rv;
    bit           exp_err;
  } vec_t;

  localparam logic [127:0] V  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] A5 = {16{8'hA5}};

  vec_t tab [11];
  logic [127:0] x0, x1, x2, x3;
  logic [127:0] rexp [4];
  logic [15:0]  raddr [4];
  int           nbusy;

  initial begin
    n_rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0, '0);
    sramInitNum = '0;
    sramDumpNum = '0;
    model_reset();
    #3;
    chk("rst_rv",   sramReadValue, 128'h0);
    chk("rst_busy", 128'(sram_busy), 128'h0);
    chk("rst_dv",   128'(dump_valid), 128'h0);
    chk("rst_dd",   dump_data, 128'h0);
    chk("rst_err",  128'(addr_error), 128'h0);
    #9 n_rst = 1'b1;

    tab[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd16,  A5, 128'h0, 1'b0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd16,  '0, 128'h0, 1'b0};
    tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,   '0, A5,     1'b0};
    tab[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd32,  V,  A5,     1'b0};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd32,  '0, A5,     1'b0};
    tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,   '0, V,      1'b0};
    tab[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd33,  '0, V,      1'b1};
    tab[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd256, A5, 128'h0, 1'b1};
    tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,   '0, 128'h0, 1'b0};
    tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd32,  '0, 128'h0, 1'b0};
    tab[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0,   '0, V,      1'b0};
    for (int i = 0; i < 11; i++) begin
      drive(tab[i].rd, tab[i].wr, tab[i].in, tab[i].dp,
            tab[i].addr, tab[i].wv);
      step();
      chk($sformatf("tab%0d_rv", i), sramReadValue, tab[i].exp_rv);
      chk($sformatf("tab%0d_err", i), 128'(addr_error),
          128'(tab[i].exp_err));
    end

    // Init wrapping past the top word
    x0 = {4{$urandom}};
    x1 = {4{$urandom}};
    x2 = {4{$urandom}};
    x3 = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    drive(0, 1, 0, 0, 16'd224, x1); step();
    drive(0, 1, 0, 0, 16'd240, x2); step();
    drive(0, 1, 0, 0, 16'd0,   x0); step();
    drive(0, 1, 0, 0, 16'd16,  x3); step();
    drive(0, 0, 1, 0, 16'd224, '0);
    sramInitNum = 3'd2;
    step();
    nbusy = int'(sram_busy);
    drive(0, 0, 0, 0, 16'd48, '0);
    sramInitNum = 3'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      nbusy += int'(sram_busy);
    end
    chk("init_busy_cycles", 128'(nbusy), 128'd3);
    raddr[0] = 16'd224; rexp[0] = '0;
    raddr[1] = 16'd240; rexp[1] = '0;
    raddr[2] = 16'd0;   rexp[2] = '0;
    raddr[3] = 16'd16;  rexp[3] = x3;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 0, 0, 0, raddr[i], '0);
      else       drive(0, 0, 0, 0, 16'd0, '0);
      step();
      if (i >= 1 && i <= 4)
        chk($sformatf("init_rd%0d", i - 1), sramReadValue, rexp[i - 1]);
    end

    // Dump of 8 words with a read strobe held throughout
    drive(0, 0, 0, 1, 16'd0, '0);
    sramDumpNum = 3'd7;
    step();
    drive(1, 0, 0, 0, 16'd32, '0);
    sramDumpNum = 3'd1;
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("dump_v%0d", b), 128'(dump_valid), 128'd1);
      chk($sformatf("dump_d%0d", b), dump_data, m_mem[b]);
      if (b == 7) drive(0, 0, 0, 0, 16'd0, '0);
      step();
    end
    chk("dump_end_v", 128'(dump_valid), 128'd0);
    chk("dump_rd_ignored", sramReadValue, x3);

    // Reset during the second beat of a dump
    drive(0, 0, 0, 1, 16'd0, '0);
    sramDumpNum = 3'd7;
    step();
    drive(0, 0, 0, 0, 16'd0, '0);
    step();
    chk("rdump_beat2", 128'(dump_valid), 128'd1);
    n_rst = 1'b0;
    #1;
    model_reset();
    chk("rdump_dv",   128'(dump_valid), 128'd0);
    chk("rdump_dd",   dump_data, 128'h0);
    chk("rdump_busy", 128'(sram_busy), 128'd0);
    chk("rdump_rv",   sramReadValue, 128'h0);
    chk("rdump_err",  128'(addr_error), 128'd0);
    #2 n_rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    drive(1, 0, 0, 0, 16'd16, '0); step();
    drive(0, 0, 0, 0, 16'd0, '0); step();
    chk("rdump_mem_clr", sramReadValue, 128'h0);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      logic [15:0] a;
      a = 16'(($urandom_range(0, 19)) * 16);
      if ($urandom_range(0, 9) == 0) a = a | 16'($urandom_range(1, 15));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
            a, {$urandom, $urandom, $urandom, $urandom});
      sramInitNum = 3'($urandom);
      sramDumpNum = 3'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
